// File: rtl/shftreg_deser.sv
// Serial-to-parallel receiver: collects `length` strobed bits per word, framed by an
// active-low sync marker, and presents each completed word through a valid/ready
// output register. Flags resyncs mid-word (frm_err) and dropped words (ovf).
module shftreg_deser #(
  parameter int unsigned length    = 6,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CntW     = $clog2(length + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_in,
  input  logic              shift_n,
  input  logic              sync_n,
  output logic [length-1:0] p_out,
  output logic              p_valid,
  input  logic              p_ready,
  output logic [CntW-1:0]   bit_cnt,
  output logic              frm_err,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam logic [CntW-1:0] LastCnt = CntW'(length - 1);

  typedef enum logic [0:0] {
    StHunt,
    StCollect
  } state_e;

  state_e state_q, state_d;

  logic [length-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [length-1:0] p_out_q, p_out_d;
  logic              p_valid_q, p_valid_d;
  logic              frm_err_q, frm_err_d;
  logic              ovf_q, ovf_d;

  logic              strobe;
  logic              sync_hit;
  logic              last_bit;
  logic              start_word;
  logic              shift_bit;
  logic              resync_err;
  logic              word_done;
  logic              overrun;
  logic              load_word;
  logic [length-1:0] shifted;
  logic [length-1:0] fresh;

  assign strobe   = ~shift_n;
  // sync_n only counts on a strobed bit
  assign sync_hit = strobe & ~sync_n;
  assign last_bit = (bit_cnt_q == LastCnt);

  // Register image after accepting s_in, and a register holding only s_in as bit 0 of a
  // new word. The first received bit travels towards the top (MSB-first) or the bottom.
  assign shifted = MSB_FIRST ? {shreg_q[length-2:0], s_in} : {s_in, shreg_q[length-1:1]};
  assign fresh   = MSB_FIRST ? {{(length - 1){1'b0}}, s_in} : {s_in, {(length - 1){1'b0}}};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave HUNT on the first qualified sync, then stay framed for good
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHunt:    if (sync_hit) state_d = StCollect;
      StCollect: state_d = StCollect;
      default:   state_d = StHunt;
    endcase
  end

  // FSM outputs: decode what the current strobe does to the word being assembled
  always_comb begin
    start_word = 1'b0;
    shift_bit  = 1'b0;
    resync_err = 1'b0;
    unique case (state_q)
      StHunt: begin
        start_word = sync_hit;
      end
      StCollect: begin
        start_word = sync_hit;
        // Sync wins over a plain shift, including on the would-be completing bit
        shift_bit  = strobe & ~sync_hit;
        resync_err = sync_hit & (bit_cnt_q != '0);
      end
      default: begin
        start_word = 1'b0;
      end
    endcase
  end

  assign word_done = shift_bit & last_bit;
  // A completed word with the previous one still held and not taken this edge is dropped
  assign overrun   = word_done & p_valid_q & ~p_ready;
  assign load_word = word_done & ~overrun;

  // Shift register and bit counter next state
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (start_word) begin
      shreg_d   = fresh;
      bit_cnt_d = CntW'(1);
    end else if (shift_bit) begin
      if (last_bit) begin
        shreg_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shreg_d   = shifted;
        bit_cnt_d = bit_cnt_q + CntW'(1);
      end
    end
  end

  // Output word register, handshake and status flags next state
  always_comb begin
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    if (load_word) begin
      // Covers both an empty register and a same-edge accept of the old word
      p_out_d   = shifted;
      p_valid_d = 1'b1;
    end else if (p_valid_q && p_ready) begin
      p_valid_d = 1'b0;
    end

    frm_err_d = resync_err;

    // Overrun set takes priority over a simultaneous clear
    if (overrun) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign bit_cnt = bit_cnt_q;
  assign frm_err = frm_err_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_shftreg_deser.sv
// Bench for shftreg_deser: an MSB-first and an LSB-first instance share one stimulus
// stream. A bit-list reference model predicts words, handshake state and flags; words
// go into per-instance queues that a negedge monitor pops on every transfer.
module tb_shftreg_deser;

  localparam int unsigned LEN = 6;
  localparam int unsigned CW  = $clog2(LEN + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_in = 1'b0;
  logic           shift_n = 1'b1;
  logic           sync_n = 1'b1;
  logic           p_ready = 1'b0;
  logic           clr_ovf = 1'b0;

  logic [LEN-1:0] p_out_m, p_out_l;
  logic           p_valid_m, p_valid_l;
  logic [CW-1:0]  bit_cnt_m, bit_cnt_l;
  logic           frm_err_m, frm_err_l;
  logic           ovf_m, ovf_l;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit             hunting = 1'b1;
  bit             cur[$];
  bit             held = 1'b0;
  bit             ovf_e = 1'b0;
  bit             frm_e = 1'b0;
  logic [LEN-1:0] exp_m[$];
  logic [LEN-1:0] exp_l[$];

  shftreg_deser #(.length(LEN), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .shift_n(shift_n), .sync_n(sync_n),
    .p_out(p_out_m), .p_valid(p_valid_m), .p_ready(p_ready), .bit_cnt(bit_cnt_m),
    .frm_err(frm_err_m), .ovf(ovf_m), .clr_ovf(clr_ovf)
  );

  shftreg_deser #(.length(LEN), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .shift_n(shift_n), .sync_n(sync_n),
    .p_out(p_out_l), .p_valid(p_valid_l), .p_ready(p_ready), .bit_cnt(bit_cnt_l),
    .frm_err(frm_err_l), .ovf(ovf_l), .clr_ovf(clr_ovf)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfers happen at the next posedge; inputs are stable by the negedge
  always @(negedge clk) begin
    if (rst_n && p_valid_m && p_ready) begin
      total++;
      if (exp_m.size() == 0) begin
        bad++;
        $display("FAIL xfer_msb: got unexpected word %0h expected none at %0t", p_out_m, $time);
      end else begin
        total--;
        chk("xfer_msb", 64'(p_out_m), 64'(exp_m.pop_front()));
      end
    end
    if (rst_n && p_valid_l && p_ready) begin
      total++;
      if (exp_l.size() == 0) begin
        bad++;
        $display("FAIL xfer_lsb: got unexpected word %0h expected none at %0t", p_out_l, $time);
      end else begin
        total--;
        chk("xfer_lsb", 64'(p_out_l), 64'(exp_l.pop_front()));
      end
    end
  end

  // Predict the effect of one clock edge from the list of bits received so far
  task automatic model_edge(input logic sh_n, input logic sy_n, input logic b,
                            input logic rdy, input logic clr);
    bit             done;
    logic [LEN-1:0] wm;
    logic [LEN-1:0] wl;
    done  = 1'b0;
    wm    = '0;
    wl    = '0;
    frm_e = 1'b0;
    if (!sh_n) begin
      if (!sy_n) begin
        if (!hunting && cur.size() != 0) frm_e = 1'b1;
        hunting = 1'b0;
        cur.delete();
        cur.push_back(b);
      end else if (!hunting) begin
        cur.push_back(b);
        if (cur.size() == LEN) begin
          for (int i = 0; i < LEN; i++) begin
            wm[LEN-1-i] = cur[i];
            wl[i]       = cur[i];
          end
          done = 1'b1;
          cur.delete();
        end
      end
    end
    if (done && held && !rdy) ovf_e = 1'b1;
    else if (clr) ovf_e = 1'b0;
    if (done && (!held || rdy)) begin
      exp_m.push_back(wm);
      exp_l.push_back(wl);
      held = 1'b1;
    end else if (held && rdy) begin
      held = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("valid_msb", 64'(p_valid_m), 64'(held));
    chk("valid_lsb", 64'(p_valid_l), 64'(held));
    chk("bit_cnt_msb", 64'(bit_cnt_m), 64'(cur.size()));
    chk("bit_cnt_lsb", 64'(bit_cnt_l), 64'(cur.size()));
    chk("frm_err_msb", 64'(frm_err_m), 64'(frm_e));
    chk("frm_err_lsb", 64'(frm_err_l), 64'(frm_e));
    chk("ovf_msb", 64'(ovf_m), 64'(ovf_e));
    chk("ovf_lsb", 64'(ovf_l), 64'(ovf_e));
    if (held && exp_m.size() != 0) chk("p_out_msb", 64'(p_out_m), 64'(exp_m[0]));
    if (held && exp_l.size() != 0) chk("p_out_lsb", 64'(p_out_l), 64'(exp_l[0]));
  endtask

  // Inputs change 2 time units after a posedge; outputs are checked at the same point
  task automatic step(input logic sh_n, input logic sy_n, input logic b,
                      input logic rdy, input logic clr);
    shift_n = sh_n;
    sync_n  = sy_n;
    s_in    = b;
    p_ready = rdy;
    clr_ovf = clr;
    model_edge(sh_n, sy_n, b, rdy, clr);
    @(posedge clk);
    #2;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    shift_n = 1'b1;
    sync_n  = 1'b1;
    s_in    = 1'b0;
    p_ready = 1'b0;
    clr_ovf = 1'b0;
    hunting = 1'b1;
    held    = 1'b0;
    ovf_e   = 1'b0;
    frm_e   = 1'b0;
    cur.delete();
    exp_m.delete();
    exp_l.delete();
    @(posedge clk);
    #2;
    chk("rst_p_out_msb", 64'(p_out_m), 64'd0);
    chk("rst_p_out_lsb", 64'(p_out_l), 64'd0);
    chk("rst_valid", 64'(p_valid_m), 64'd0);
    chk("rst_bit_cnt", 64'(bit_cnt_m), 64'd0);
    chk("rst_frm_err", 64'(frm_err_m), 64'd0);
    chk("rst_ovf", 64'(ovf_m), 64'd0);
    rst_n = 1'b1;
  endtask

  // Send the top nbits of w, first bit = w[LEN-1]; optional sync on the first bit,
  // optional idle gaps, and a separate ready level for the final bit
  task automatic send_bits(input logic [LEN-1:0] w, input int nbits, input bit with_sync,
                           input bit gaps, input logic rdy, input logic last_rdy);
    for (int i = 0; i < nbits; i++) begin
      if (gaps && i != 0) step(1'b1, 1'($urandom), 1'($urandom), rdy, 1'b0);
      step(1'b0, !(with_sync && i == 0), w[LEN-1-i], (i == nbits - 1) ? last_rdy : rdy, 1'b0);
    end
  endtask

  initial begin
    do_reset();

    // Strobed bits without sync are ignored while hunting
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Basic back-to-back word, consumer always ready
    send_bits(6'b101101, LEN, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Same bits with idle gaps between strobes
    send_bits(6'b101101, LEN, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Resync after 3 bits, then a full word
    send_bits(6'b111000, 3, 1'b1, 1'b0, 1'b1, 1'b1);
    send_bits(6'b010011, LEN, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Sync on what would have been the completing bit: no word, frm_err
    send_bits(6'b110011, LEN - 1, 1'b1, 1'b0, 1'b1, 1'b1);
    send_bits(6'b100110, LEN, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Backpressure: second word overruns, then clear and accept together
    send_bits(6'b110001, LEN, 1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(6'b001110, LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Accept on the same edge the next word completes
    send_bits(6'b011010, LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(6'b100101, LEN, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset mid-word and with a pending word
    send_bits(6'b111111, LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(6'b101010, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) != 0), 1'($urandom),
             1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      end
    end

    // Drain anything still held
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("drain_msb", 64'(exp_m.size()), 64'd0);
    chk("drain_lsb", 64'(exp_l.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shftreg_deser.md
Name: shftreg_deser

Overview:
Serial-to-parallel receiver for the bitstream produced by the team's parallel-load shift register, which serialises MSB first from its top bit. The block collects `length` bits per word, framed by an active-low sync strobe. It presents each completed word on a held output register with a valid/ready handshake, and flags framing errors and overruns. It sits at the receive end of a serial link, between the line sampler and the word-level datapath.

Parameters:
length, 6, word width in bits; legal range 2..64
MSB_FIRST, 1, 1 = first received bit lands in p_out[length-1]; 0 = first received bit lands in p_out[0]

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
s_in  input  1  serial data bit, sampled only when shift_n=0
shift_n  input  1  active-low bit strobe; one bit is accepted per clk edge while low
sync_n  input  1  active-low frame marker; qualified by shift_n=0, it marks the current bit as bit 0 of a word
p_out  output  length  completed word (output register)
p_valid  output  1  p_out holds an unconsumed word
p_ready  input  1  consumer accepts p_out when p_valid=1 and p_ready=1
bit_cnt  output  ceil(log2(length+1))  bits collected in the current word
frm_err  output  1  one-cycle pulse: sync arrived mid-word and the partial word was discarded
ovf  output  1  sticky overrun flag
clr_ovf  input  1  synchronous clear of ovf

Behaviour:
- Reset (async, rst_n=0):
  - p_out=0, p_valid=0, bit_cnt=0, frm_err=0, ovf=0, internal shift register=0, state=HUNT.
  - Reset applied mid-word discards the partial word and any pending output word.
- States:
  - HUNT: bits are ignored until shift_n=0 and sync_n=0 in the same cycle. That bit is captured as bit 0, bit_cnt becomes 1, and the state moves to COLLECT.
  - COLLECT: each cycle with shift_n=0 shifts s_in into the shift register and increments bit_cnt. Framing is continuous; the block never returns to HUNT except through reset.
- shift_n=1 freezes the shift register and bit_cnt; sync_n is ignored in that cycle.
- Word completion: a strobed bit arriving with bit_cnt=length-1 completes the word.
  - The assembled word, including the current s_in, is written to p_out at that same edge.
  - p_valid=1 after that edge, so latency from the last-bit edge to p_valid is 1 cycle.
  - bit_cnt returns to 0.
- Bit order:
  - MSB_FIRST=1: shift left, new bit in bit 0; the first bit ends in p_out[length-1].
  - MSB_FIRST=0: shift right, new bit in bit length-1; the first bit ends in p_out[0].
- Sync in COLLECT (shift_n=0 and sync_n=0):
  - bit_cnt=0: normal word start, no error.
  - bit_cnt>0: partial word discarded, current bit taken as bit 0, bit_cnt=1, frm_err pulses high for exactly one cycle. p_out and p_valid are unaffected.
- Sync coinciding with the completing bit (bit_cnt=length-1): sync wins. The partial word is discarded, frm_err pulses, and no word is produced.
- Handshake:
  - p_out and p_valid hold stable while p_valid=1 and p_ready=0.
  - A transfer occurs at an edge where p_valid=1 and p_ready=1. p_valid then drops to 0 unless a new word completes at the same edge.
  - p_ready is ignored while p_valid=0.
- Simultaneous accept and completion (p_valid=1, p_ready=1, word completes): the new word loads, p_valid stays 1, no overflow.
- Overrun (word completes while p_valid=1 and p_ready=0):
  - The new word is dropped and p_out keeps the old word.
  - ovf is set and stays set until clr_ovf=1.
  - bit_cnt still returns to 0.
- ovf priority: clr_ovf clears ovf at the next edge; if an overrun occurs in the same cycle, set wins.
- bit_cnt never exceeds length-1 when observed.

Test Plan:
- Reset/idle: rst_n low, then release, no strobes -> all outputs 0, state HUNT. Strobed bits with sync_n=1 -> bit_cnt stays 0, p_valid stays 0.
- Basic word (length=6, MSB_FIRST=1, p_ready=1): sync on the first bit, stream 1,0,1,1,0,1 on consecutive cycles -> p_out=6'b101101 with p_valid=1 for 1 cycle, 1 cycle after the 6th bit; bit_cnt sequence 1..5, then 0.
- Gapped strobes and LSB mode (MSB_FIRST=0): same bits with shift_n=1 gaps between them -> p_out=6'b101101 reversed (6'b101101 -> 6'b101101 read LSB-first, i.e. p_out[0]=1, p_out[1]=0, p_out[2]=1, p_out[3]=1, p_out[4]=0, p_out[5]=1); bit_cnt holds during gaps.
- Resync: sync asserted at bit_cnt=3 -> frm_err high for 1 cycle, bit_cnt=1. The next word completes 5 bits later with correct content; the earlier partial word is never output.
- Backpressure/overrun: p_ready=0, two full words streamed -> p_out holds the first word, ovf=1 at the second completion. Then clr_ovf=1 and p_ready=1 together -> first word transferred, ovf=0, p_valid=0.
- Accept on completion: p_valid=1, and p_ready=1 in the same cycle the next word completes -> p_valid stays 1, p_out updates to the new word, ovf stays 0.
